// File: rtl/bus_timer_slave_pkg.sv
// Shared constants for the bus timer slave: bus widths and polarities, register map,
// control/interrupt bit positions and handshake FSM encoding (PRESC used with TIMER_PRESCALER_EN).
package bus_timer_slave_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;

    // Bus strobes and ready are active-low; RW high means read.
    localparam logic ASSERTED_L = 1'b0;
    localparam logic RW_READ    = 1'b1;

    localparam logic [ADDR_W-1:0] OFF_CTRL  = 3'd0;
    localparam logic [ADDR_W-1:0] OFF_INTR  = 3'd1;
    localparam logic [ADDR_W-1:0] OFF_EXPR  = 3'd2;
    localparam logic [ADDR_W-1:0] OFF_COUNT = 3'd3;
    localparam logic [ADDR_W-1:0] OFF_PRESC = 3'd4;

    localparam int CTRL_START_BIT    = 0;
    localparam int CTRL_PERIODIC_BIT = 1;
    localparam int INTR_FLAG_BIT     = 0;

    localparam int PRESC_W = 8;

    localparam int DEFAULT_WAIT_STATES = 0;
    localparam int WAIT_CNT_W          = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } resp_state_t;

endpackage

// File: rtl/bus_slave_resp.sv
// Generic bus slave handshake: accepts a strobed transaction, inserts WAIT_STATES wait
// cycles, then pulses ready for one cycle together with a commit strobe and latched request.
module bus_slave_resp
    import bus_timer_slave_pkg::*;
#(
    parameter int WAIT_STATES = DEFAULT_WAIT_STATES
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              cs_,
    input  logic              as_,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rdy_,
    output logic              commit,
    output logic              lat_rw,
    output logic [ADDR_W-1:0] lat_addr,
    output logic [DATA_W-1:0] lat_wr_data
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;

    resp_state_t           state;
    resp_state_t           state_nxt;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic [WAIT_CNT_W-1:0] wait_nxt;
    logic                  accept;

    // Strobes outside IDLE are dropped: the initiator never has a second transaction pending.
    assign accept = (state == ST_IDLE) && (cs_ == ASSERTED_L) && (as_ == ASSERTED_L);

    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        rdy_      = ~ASSERTED_L;
        commit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT_STATES > 0) begin
                        state_nxt = ST_WAIT;
                        wait_nxt  = WAIT_LOAD;
                    end else begin
                        state_nxt = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt == '0) begin
                    state_nxt = ST_RESP;
                end else begin
                    wait_nxt = wait_cnt - 1'b1;
                end
            end
            ST_RESP: begin
                rdy_      = ASSERTED_L;
                commit    = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            lat_rw      <= 1'b0;
            lat_addr    <= '0;
            lat_wr_data <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (accept) begin
                lat_rw      <= rw;
                lat_addr    <= addr;
                lat_wr_data <= wr_data;
            end
        end
    end

endmodule

// File: rtl/bus_timer_slave.sv
// Bus-attached programmable interval timer with CTRL/INTR/EXPR/COUNT registers and an
// interrupt output. Define TIMER_PRESCALER_EN to add the PRESC tick divider at offset 4.
module bus_timer_slave
    import bus_timer_slave_pkg::*;
#(
    parameter int WAIT_STATES = DEFAULT_WAIT_STATES
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              Cs_,
    input  logic              As_,
    input  logic              RW,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WrData,
    output logic [DATA_W-1:0] RdData,
    output logic              Rdy_,
    output logic              Irq
);

    logic              commit;
    logic              lat_rw;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wr_data;

    logic              start;
    logic              periodic;
    logic              flag;
    logic [DATA_W-1:0] expr;
    logic [DATA_W-1:0] count;

    logic              wr_en;
    logic              rd_en;
    logic              tick;
    logic              tick_en;
    logic              expire;
    logic [DATA_W-1:0] rd_sel;

    bus_slave_resp #(
        .WAIT_STATES (WAIT_STATES)
    ) u_resp (
        .clk         (clk),
        .reset_      (reset_),
        .cs_         (Cs_),
        .as_         (As_),
        .rw          (RW),
        .addr        (Addr),
        .wr_data     (WrData),
        .rdy_        (Rdy_),
        .commit      (commit),
        .lat_rw      (lat_rw),
        .lat_addr    (lat_addr),
        .lat_wr_data (lat_wr_data)
    );

    assign wr_en = commit && (lat_rw != RW_READ);
    assign rd_en = commit && (lat_rw == RW_READ);

`ifdef TIMER_PRESCALER_EN
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] presc_cnt;
    logic               presc_wr;

    assign presc_wr = wr_en && (lat_addr == OFF_PRESC);
    assign tick     = (presc_cnt == presc);

    // Holding the divider at zero while stopped makes every START 0->1 begin a fresh period.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            presc     <= '0;
            presc_cnt <= '0;
        end else begin
            if (presc_wr) begin
                presc <= lat_wr_data[PRESC_W-1:0];
            end
            if (!start || presc_wr || tick) begin
                presc_cnt <= '0;
            end else begin
                presc_cnt <= presc_cnt + 1'b1;
            end
        end
    end
`else
    assign tick = 1'b1;
`endif

    assign tick_en = start && tick;
    assign expire  = tick_en && (count == expr);
    assign Irq     = flag;

    // Bus writes follow the timer update so they win the same edge; an expiry still wins over clearing FLAG.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            start    <= 1'b0;
            periodic <= 1'b0;
            flag     <= 1'b0;
            expr     <= '0;
            count    <= '0;
        end else begin
            if (tick_en) begin
                if (expire) begin
                    count <= '0;
                    flag  <= 1'b1;
                    if (!periodic) begin
                        start <= 1'b0;
                    end
                end else begin
                    count <= count + 32'd1;
                end
            end
            if (wr_en) begin
                case (lat_addr)
                    OFF_CTRL: begin
                        start    <= lat_wr_data[CTRL_START_BIT];
                        periodic <= lat_wr_data[CTRL_PERIODIC_BIT];
                    end
                    OFF_INTR: begin
                        if (!expire) begin
                            flag <= lat_wr_data[INTR_FLAG_BIT];
                        end
                    end
                    OFF_EXPR:  expr  <= lat_wr_data;
                    OFF_COUNT: count <= lat_wr_data;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_sel = '0;
        case (lat_addr)
            OFF_CTRL: begin
                rd_sel[CTRL_START_BIT]    = start;
                rd_sel[CTRL_PERIODIC_BIT] = periodic;
            end
            OFF_INTR:  rd_sel[INTR_FLAG_BIT] = flag;
            OFF_EXPR:  rd_sel = expr;
            OFF_COUNT: rd_sel = count;
`ifdef TIMER_PRESCALER_EN
            OFF_PRESC: rd_sel[PRESC_W-1:0] = presc;
`endif
            default: ;
        endcase
    end

    assign RdData = rd_en ? rd_sel : '0;

endmodule

// File: tb/tb_bus_timer_slave.sv
// Directed bench for bus_timer_slave: one instance with no wait states, one with three,
// covering handshake latency, one-shot/periodic timer, reserved offsets and reset aborts.
module tb_bus_timer_slave;
    import bus_timer_slave_pkg::*;

    logic        clk;
    logic        reset_;
    logic        cs0_;
    logic        cs3_;
    logic        as_;
    logic        rw;
    logic [2:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd0;
    logic [31:0] rd3;
    logic        rdy0_;
    logic        rdy3_;
    logic        irq0;
    logic        irq3;

    int checks = 0;
    int errors = 0;

    bus_timer_slave #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .reset_(reset_), .Cs_(cs0_), .As_(as_), .RW(rw), .Addr(addr),
        .WrData(wr_data), .RdData(rd0), .Rdy_(rdy0_), .Irq(irq0)
    );

    bus_timer_slave #(.WAIT_STATES(3)) dut3 (
        .clk(clk), .reset_(reset_), .Cs_(cs3_), .As_(as_), .RW(rw), .Addr(addr),
        .WrData(wr_data), .RdData(rd3), .Rdy_(rdy3_), .Irq(irq3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic stepCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One transaction; lat counts cycles after the strobe cycle until Rdy_ is seen (0 = never).
    task automatic applyStimulus(input bit sel3, input bit is_read, input logic [2:0] a,
                                 input logic [31:0] d, output logic [31:0] rdata, output int lat);
        @(posedge clk); #1;
        if (sel3) cs3_ = 1'b0; else cs0_ = 1'b0;
        as_ = 1'b0; rw = is_read; addr = a; wr_data = d;
        @(posedge clk); #1;
        cs0_ = 1'b1; cs3_ = 1'b1; as_ = 1'b1;
        lat = 0;
        rdata = 32'hDEAD_BEEF;
        for (int i = 1; i <= 20; i++) begin
            if ((sel3 ? rdy3_ : rdy0_) == 1'b0) begin
                lat = i;
                rdata = sel3 ? rd3 : rd0;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat == 0) begin
            checkOutput("rdy_timeout", 32'(lat), 32'd1);
        end else begin
            @(posedge clk); #1;
            checkOutput("rdy_release", {31'd0, (sel3 ? rdy3_ : rdy0_)}, 32'd1);
        end
    endtask

    task automatic writeReg(input string tag, input logic [2:0] a, input logic [31:0] d);
        logic [31:0] r;
        int          lat;
        applyStimulus(1'b0, 1'b0, a, d, r, lat);
        checkOutput({tag, "_wlat"}, 32'(lat), 32'd1);
        checkOutput({tag, "_wdata0"}, r, 32'd0);
    endtask

    task automatic readReg(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] r;
        int          lat;
        applyStimulus(1'b0, 1'b1, a, 32'h0, r, lat);
        checkOutput({tag, "_rlat"}, 32'(lat), 32'd1);
        checkOutput(tag, r, exp);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          first_low;
        int          pulses;
        logic [31:0] rd_capture;

        reset_ = 1'b0; cs0_ = 1'b1; cs3_ = 1'b1; as_ = 1'b1;
        rw = 1'b1; addr = 3'd0; wr_data = 32'd0;
        stepCycles(3);
        reset_ = 1'b1;
        checkOutput("reset_rdy0", {31'd0, rdy0_}, 32'd1);
        checkOutput("reset_rdy3", {31'd0, rdy3_}, 32'd1);
        checkOutput("reset_rd0", rd0, 32'd0);
        checkOutput("reset_irq0", {31'd0, irq0}, 32'd0);
        readReg("reset_count", OFF_COUNT, 32'd0);

        writeReg("ws0_expr", OFF_EXPR, 32'h0000_000A);
        readReg("ws0_expr_rd", OFF_EXPR, 32'h0000_000A);

        // Three wait states: strobe at k=0, stray strobe at k=2 must be ignored.
        @(posedge clk); #1;
        cs3_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = OFF_COUNT;
        first_low = 0; pulses = 0; rd_capture = 32'hDEAD_BEEF;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (!rdy3_) begin
                pulses++;
                rd_capture = rd3;
                if (first_low == 0) first_low = k;
            end
            if (k == 2) begin cs3_ = 1'b0; as_ = 1'b0; end
            else begin cs3_ = 1'b1; as_ = 1'b1; end
        end
        checkOutput("ws3_latency", 32'(first_low), 32'd4);
        checkOutput("ws3_pulses", 32'(pulses), 32'd1);
        checkOutput("ws3_rdata", rd_capture, 32'd0);

        // One-shot: expires on the fourth tick after START.
        writeReg("os_expr", OFF_EXPR, 32'd3);
        writeReg("os_ctrl", OFF_CTRL, 32'h1);
        stepCycles(3);
        checkOutput("os_irq_before", {31'd0, irq0}, 32'd0);
        stepCycles(1);
        checkOutput("os_irq_after", {31'd0, irq0}, 32'd1);
        readReg("os_count", OFF_COUNT, 32'd0);
        readReg("os_ctrl_rd", OFF_CTRL, 32'd0);
        readReg("os_intr_rd", OFF_INTR, 32'd1);
        writeReg("os_clr", OFF_INTR, 32'd0);
        checkOutput("os_irq_cleared", {31'd0, irq0}, 32'd0);

        // Periodic with EXPR=2: expiries every third edge after START (E3, E6, E9, E12).
        writeReg("per_expr", OFF_EXPR, 32'd2);
        writeReg("per_ctrl", OFF_CTRL, 32'h3);
        stepCycles(2);
        checkOutput("per_irq_e2", {31'd0, irq0}, 32'd0);
        stepCycles(1);
        checkOutput("per_irq_e3", {31'd0, irq0}, 32'd1);
        stepCycles(1);
        writeReg("per_clr_e7", OFF_INTR, 32'd0);
        checkOutput("per_irq_e7", {31'd0, irq0}, 32'd0);
        stepCycles(2);
        checkOutput("per_irq_e9", {31'd0, irq0}, 32'd1);
        writeReg("per_clr_e12", OFF_INTR, 32'd0);
        checkOutput("per_clr_vs_expiry", {31'd0, irq0}, 32'd1);

        writeReg("stop_ctrl", OFF_CTRL, 32'd0);
        writeReg("stop_intr", OFF_INTR, 32'd0);
        writeReg("set_count", OFF_COUNT, 32'h55);
        writeReg("set_expr", OFF_EXPR, 32'h77);
        writeReg("rsv6_wr", 3'd6, 32'hFFFF_FFFF);
        readReg("rsv6_ctrl", OFF_CTRL, 32'd0);
        readReg("rsv6_intr", OFF_INTR, 32'd0);
        readReg("rsv6_expr", OFF_EXPR, 32'h77);
        readReg("rsv6_count", OFF_COUNT, 32'h55);
        readReg("rsv6_rd", 3'd6, 32'd0);
        checkOutput("rsv6_irq", {31'd0, irq0}, 32'd0);

        // Reset while dut3 sits in WAIT: no ready may ever appear.
        @(posedge clk); #1;
        cs3_ = 1'b0; as_ = 1'b0; rw = 1'b1; addr = OFF_COUNT;
        @(posedge clk); #1;
        cs3_ = 1'b1; as_ = 1'b1;
        pulses = 0;
        @(posedge clk); #1;
        if (!rdy3_) pulses++;
        reset_ = 1'b0;
        #1;
        checkOutput("rst_irq0", {31'd0, irq0}, 32'd0);
        for (int k = 0; k < 10; k++) begin
            if (k == 2) reset_ = 1'b1;
            @(posedge clk); #1;
            if (!rdy3_) pulses++;
        end
        checkOutput("rst_no_rdy", 32'(pulses), 32'd0);
        readReg("rst_count", OFF_COUNT, 32'd0);
        readReg("rst_expr", OFF_EXPR, 32'd0);
        readReg("rst_intr", OFF_INTR, 32'd0);

`ifdef TIMER_PRESCALER_EN
        writeReg("pre_presc", OFF_PRESC, 32'd4);
        readReg("pre_presc_rd", OFF_PRESC, 32'd4);
        writeReg("pre_expr", OFF_EXPR, 32'd1);
        writeReg("pre_ctrl", OFF_CTRL, 32'h1);
        stepCycles(9);
        checkOutput("pre_irq_9", {31'd0, irq0}, 32'd0);
        stepCycles(1);
        checkOutput("pre_irq_10", {31'd0, irq0}, 32'd1);
`else
        writeReg("off4_wr", OFF_PRESC, 32'hFFFF_FFFF);
        readReg("off4_rd", OFF_PRESC, 32'd0);
        readReg("off4_ctrl", OFF_CTRL, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
